// File: rtl/lcd_spi_write.sv
// Write-only 4-wire SPI (mode 0) output stage for the LCD path.
// Each accepted 9-bit word becomes a DC level plus an MSB-first byte framed by CS_N.
module lcd_spi_write #(
  parameter int CLK_DIV = 2
) (
  input  logic       sys_clk_50MHz,
  input  logic       sys_rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       busy,
  output logic       wr_done,
  output logic       lcd_sclk,
  output logic       lcd_mosi,
  output logic       lcd_dc,
  output logic       lcd_cs_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             last_rise_r;
  logic             div_tc_s;

  assign div_tc_s = (div_cnt_r == DIV_TC);

  // Transfer sequencer: framing, SCLK generation and bit shifting.
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= IDLE;
      div_cnt_r   <= '0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      last_rise_r <= 1'b0;
      busy        <= 1'b0;
      wr_done     <= 1'b0;
      lcd_sclk    <= 1'b0;
      lcd_mosi    <= 1'b0;
      lcd_dc      <= 1'b0;
      lcd_cs_n    <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          wr_done   <= 1'b0;
          div_cnt_r <= '0;
          if (en_write) begin
            shift_r     <= data[7:0];
            lcd_dc      <= data[8];
            lcd_mosi    <= data[7];
            lcd_cs_n    <= 1'b0;
            busy        <= 1'b1;
            bit_cnt_r   <= 3'd0;
            last_rise_r <= 1'b0;
            state_r     <= SETUP;
          end else begin
            busy <= 1'b0;
          end
        end
        SETUP: begin
          if (div_tc_s) begin
            div_cnt_r <= '0;
            state_r   <= SHIFT;
          end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
          end
        end
        SHIFT: begin
          if (div_tc_s) begin
            div_cnt_r <= '0;
            lcd_sclk  <= ~lcd_sclk;
            if (!lcd_sclk) begin
              // last_rise_r marks that all 8 rising edges are done; the counter itself wraps to 0.
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                last_rise_r <= 1'b1;
              end else begin
                last_rise_r <= last_rise_r;
              end
            end else if (last_rise_r) begin
              lcd_mosi <= 1'b0;
              state_r  <= HOLD;
            end else begin
              shift_r  <= {shift_r[6:0], 1'b0};
              lcd_mosi <= shift_r[6];
            end
          end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
          end
        end
        HOLD: begin
          if (div_tc_s) begin
            div_cnt_r <= '0;
            lcd_cs_n  <= 1'b1;
            wr_done   <= 1'b1;
            state_r   <= DONE;
          end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
          end
        end
        DONE: begin
          div_cnt_r <= '0;
          wr_done   <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          div_cnt_r <= '0;
          busy      <= 1'b0;
          wr_done   <= 1'b0;
          lcd_sclk  <= 1'b0;
          lcd_mosi  <= 1'b0;
          lcd_cs_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule
